// File: rtl/shift_operand_stage_pkg.sv
// rtl/shift_operand_stage_pkg.sv - shared constants, FSM states and entry type for shift_operand_stage
package shift_operand_stage_pkg;

  localparam int ENT_DATA_W  = 32;
  localparam int ENT_SHAMT_W = 5;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [5:0] FN_SRL  = 6'h10;
  localparam logic [5:0] FN_SLL  = 6'h11;
  localparam logic [5:0] FN_ROR  = 6'h12;
  localparam logic [5:0] FN_ROL  = 6'h13;
  localparam logic [5:0] FN_SRLV = 6'h14;
  localparam logic [5:0] FN_SLLV = 6'h15;
  localparam logic [5:0] FN_RORV = 6'h16;
  localparam logic [5:0] FN_ROLV = 6'h17;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENT_DATA_W-1:0]  a;
    logic [1:0]             op;
    logic [ENT_SHAMT_W-1:0] bits;
    logic [4:0]             rd;
    logic                   illegal;
  } entry_t;

  function automatic logic [1:0] shift_op_of(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SLLV: shift_op_of = SH_SLL;
      FN_ROR, FN_RORV: shift_op_of = SH_ROR;
      FN_ROL, FN_ROLV: shift_op_of = SH_ROL;
      default:         shift_op_of = SH_SRL;
    endcase
  endfunction

endpackage

// File: rtl/shift_operand_stage_decode.sv
// rtl/shift_operand_stage_decode.sv - combinational R-type shift decoder producing one stage entry
module shift_decode
  import shift_operand_stage_pkg::*;
(
  input  logic [31:0]           i_instr,
  input  logic [ENT_DATA_W-1:0] i_rs_op,
  input  logic [ENT_DATA_W-1:0] i_rt_op,
  output entry_t                o_entry
);

  logic [5:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_shamt;
  logic [5:0] w_funct;
  logic       w_unused_fields;

  assign w_opcode        = i_instr[31:26];
  assign w_rd            = i_instr[25:21];
  assign w_shamt         = i_instr[10:6];
  assign w_funct         = i_instr[5:0];
  assign w_unused_fields = ^i_instr[20:11];

  // Illegal encodings still carry rs so the entry flows with a defined payload.
  always_comb begin
    o_entry         = '0;
    o_entry.a       = i_rs_op;
    o_entry.illegal = 1'b1;
    if (w_opcode == OPC_RTYPE) begin
      case (w_funct)
        FN_SRL, FN_SLL, FN_ROR, FN_ROL: begin
          o_entry.op      = shift_op_of(w_funct);
          o_entry.bits    = w_shamt;
          o_entry.rd      = w_rd;
          o_entry.illegal = 1'b0;
        end
        FN_SRLV, FN_SLLV, FN_RORV, FN_ROLV: begin
          o_entry.op      = shift_op_of(w_funct);
          o_entry.bits    = i_rt_op[ENT_SHAMT_W-1:0];
          o_entry.rd      = w_rd;
          o_entry.illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// rtl/shift_operand_stage.sv - ID/EX shift operand stage with 2-entry skid buffer; SHIFT_FWD_EN enables writeback forwarding
module shift_operand_stage
  import shift_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [DATA_W-1:0]  in_rs_val,
  input  logic [DATA_W-1:0]  in_rt_val,
  input  logic               wb_en,
  input  logic [4:0]         wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [1:0]         out_op,
  output logic [SHAMT_W-1:0] out_bits,
  output logic [4:0]         out_rd,
  output logic               out_illegal
);

  state_t            r_state;
  state_t            w_state_nxt;
  entry_t            r_main;
  entry_t            r_skid;
  entry_t            w_dec;
  logic [DATA_W-1:0] w_rs_op;
  logic [DATA_W-1:0] w_rt_op;
  logic              w_accept;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_skid_to_main;

  always_comb begin
    w_rs_op = in_rs_val;
    w_rt_op = in_rt_val;
`ifdef SHIFT_FWD_EN
    // Operands are resolved once here; held entries keep what they captured.
    if (wb_en && (wb_rd == in_instr[20:16]) && (in_instr[20:16] != 5'd0))
      w_rs_op = wb_data;
    if (wb_en && (wb_rd == in_instr[15:11]) && (in_instr[15:11] != 5'd0))
      w_rt_op = wb_data;
`endif
  end

`ifndef SHIFT_FWD_EN
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_rd, wb_data};
`endif

  shift_decode u_decode (
    .i_instr (in_instr),
    .i_rs_op (w_rs_op),
    .i_rt_op (w_rt_op),
    .o_entry (w_dec)
  );

  assign in_ready = (r_state != ST_FULL) && reset_n;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && out_ready) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main)
        r_main <= w_dec;
      else if (w_skid_to_main)
        r_main <= r_skid;
      if (w_load_skid)
        r_skid <= w_dec;
    end
  end

  assign out_valid   = (r_state != ST_EMPTY);
  assign out_a       = r_main.a;
  assign out_op      = r_main.op;
  assign out_bits    = r_main.bits;
  assign out_rd      = r_main.rd;
  assign out_illegal = r_main.illegal;

endmodule
